trigger_unit: RTL and testbench
===============================

// Module: trigger_unit
// PURPOSE
//  Parametrised successor of the two-trigger CSR file: NUM_TRIG mcontrol (type 2) triggers with
//  tselect/tdata1/tdata2/tdata3/tinfo CSRs, built-in address match on fetch PC and load/store
//  address, sticky hit bits and a registered breakpoint/debug-entry request held until acknowledged.
//  Sits beside the machine CSR file; core and debug-module register accesses both land here.
// PARAMETERS
//  NUM_TRIG    4   number of triggers (1..16)
//  DATA_WIDTH  32  CSR / address width
//  SEL_W       $clog2(NUM_TRIG) (min 1)  derived, tselect storage width
// PORTS
//  cpu_clk         in  1      cpu clock
//  cpu_rstn        in  1      asynchronous reset, active low
//  csr_addr        in  12     core CSR address
//  valid_mcsr_rd   in  1      core CSR read
//  valid_mcsr_wr   in  1      core CSR write
//  mcsr_set/clr    in  1/1    CSRRS / CSRRC modifier of the write
//  write_data      in  DW     core write data
//  read_data       out DW     read data (0 when no hit address or no read)
//  dbg_mode        in  1      hart in debug mode
//  dbg_csr_wr      in  1      debugger CSR write (plain write, no set/clr)
//  dbg_csr_addr    in  12     debugger CSR address
//  dbg_write_data  in  DW     debugger write data
//  if_valid/if_pc  in  1/DW   fetch valid and PC (execute match)
//  mem_valid       in  1      load/store address valid
//  mem_st          in  1      1 store, 0 load
//  mem_addr        in  DW     load/store address
//  trig_req        out 1      trigger fired, pending
//  trig_dbg        out 1      with trig_req: 1 enter debug, 0 breakpoint exception
//  trig_idx        out SEL_W  index of the firing trigger
//  trig_ack        in  1      core consumed request
// BEHAVIOUR
//  Reset: tselect=0, all tdata1 fields 0 except type reads 2, tdata2=0, trig_req/dbg/idx=0.
//  CSRs: tselect 0x7A0, tdata1 0x7A1, tdata2 0x7A2, tdata3 0x7A3 (reads 0, writes ignored),
//   tinfo 0x7A4 (reads 1<<2). tdata1/2 access the trigger selected by tselect.
//  Debugger write and core write in same cycle: debugger wins, core write dropped.
//  tselect WARL: write value >= NUM_TRIG ignored (keeps old value).
//  tdata1 fields: type[31:28]=2 RO, dmode[27], maskmax/select/timing/chain/u/s = 0 RO, hit[20],
//   action[15:12], match[10:7], m[6], execute[2], store[1], load[0].
//   action WARL {0,1}, other -> 0; match WARL {0 eq,2 >=,3 <}, other -> 0.
//   dmode writable only when dbg_mode=1 or debugger write; when selected trigger has dmode=1,
//   core writes to its tdata1/tdata2 outside debug mode are ignored. action=1 requires dmode=1,
//   else stored as 0. set/clr apply to the stored value, then WARL legalisation.
//  Match (per trigger i, combinational): m=1 and not dbg_mode and
//   (execute & if_valid & cmp(if_pc)) | ((mem_st?store:load) & mem_valid & cmp(mem_addr));
//   cmp unsigned against tdata2_i per match field. Multiple hits: lowest index fires.
//  Hit: every matching trigger sets its hit bit at next edge; cleared only by CSR write.
//  Request: idle & any match -> next cycle trig_req=1, trig_idx, trig_dbg=action of that trigger
//   (latency 1). Held stable until trig_ack sampled high; cleared next edge. Matches while pending
//   set hit bits only. ack and new match same cycle: new request loaded (back-to-back, no bubble).
//  Entering dbg_mode with trig_req pending: request cleared. Reset mid-request: all cleared.
// STRUCTURE
//  Shared package/defines: CSR addresses, tdata1 field offsets, match/action encodings, TYPE_MC=2.
//  Sub-module trigger_match (one per trigger, generate loop): comparator + enable qualification,
//  output match_i. Register file, WARL logic, priority encoder and request FSM in this module.
// TESTING
//  Reset -> read tdata1 of trig 0 = 0x2000_0000, tselect=0, trig_req=0.
//  tselect<=NUM_TRIG (4) -> readback unchanged; tselect<=3 then tdata2<=0x8000_0100 -> reads back.
//  Trig1 exec eq 0x100, m=1, action 0; if_pc=0x100 -> trig_req, idx=1, dbg=0 one cycle later,
//   hit=1; held 5 cycles until ack, cleared the cycle after.
//  Trig0 load >= 0x2000 and trig2 store < 0x10: store to 0x8 and pending ack -> idx=2; load 0x3000
//   while pending -> only trig0 hit set; ack + load same cycle -> new req idx 0 with no gap.
//  dmode=1 written outside debug -> stays 0; in debug set dmode, action=1 -> core write later ignored,
//   match fires with trig_dbg=1; action=5 write -> reads 0; match=1 write -> reads 0.
//  dbg_mode=1 with matching PC -> no hit, no req; pending req cleared on debug entry.

Source files
------------

// File: rtl/trigger_unit_pkg.sv
// Trigger unit shared definitions: CSR addresses, tdata1 layout,
// match/action encodings, stored tdata1 record and pack/legalise helpers.
package trigger_unit_pkg;

  localparam logic [11:0] CSR_TSELECT = 12'h7A0;
  localparam logic [11:0] CSR_TDATA1  = 12'h7A1;
  localparam logic [11:0] CSR_TDATA2  = 12'h7A2;
  localparam logic [11:0] CSR_TDATA3  = 12'h7A3;
  localparam logic [11:0] CSR_TINFO   = 12'h7A4;

  localparam logic [3:0] TYPE_MC = 4'd2;

  localparam int TD1_DMODE = 27;
  localparam int TD1_HIT   = 20;
  localparam int TD1_ACT   = 12;
  localparam int TD1_MATCH = 7;
  localparam int TD1_M     = 6;
  localparam int TD1_EXEC  = 2;
  localparam int TD1_STORE = 1;
  localparam int TD1_LOAD  = 0;

  localparam logic [3:0] ACT_BRK = 4'd0;
  localparam logic [3:0] ACT_DBG = 4'd1;

  localparam logic [1:0] MATCH_EQ = 2'd0;
  localparam logic [1:0] MATCH_GE = 2'd2;
  localparam logic [1:0] MATCH_LT = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } req_state_e;

  // Only the writable tdata1 bits are stored; action is {0,1}
  // and match is {0,2,3}, so narrow fields suffice.
  typedef struct packed {
    logic       dmode;
    logic       hit;
    logic       act;
    logic [1:0] mtch;
    logic       m;
    logic       exec;
    logic       store;
    logic       load;
  } tdata1_t;

  function automatic logic [31:0] pack_td1(tdata1_t t);
    return {TYPE_MC, t.dmode, 6'b0, t.hit, 4'b0,
            3'b0, t.act, 1'b0, 2'b0, t.mtch,
            t.m, 3'b0, t.exec, t.store, t.load};
  endfunction

  function automatic logic [1:0] legal_match(logic [3:0] v);
    logic [1:0] r;
    r = MATCH_EQ;
    if (v == {2'b0, MATCH_GE}) r = MATCH_GE;
    if (v == {2'b0, MATCH_LT}) r = MATCH_LT;
    return r;
  endfunction

endpackage

// File: rtl/trigger_unit_if.sv
// CSR access bus of the trigger unit: core read/write with set/clr
// modifiers plus the debugger write path. master = core side, slave = unit.
interface trigger_unit_if #(
  parameter int DW = 32
);
  logic [11:0]   csr_addr;
  logic          valid_mcsr_rd;
  logic          valid_mcsr_wr;
  logic          mcsr_set;
  logic          mcsr_clr;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;
  logic          dbg_csr_wr;
  logic [11:0]   dbg_csr_addr;
  logic [DW-1:0] dbg_write_data;

  modport master (
    output csr_addr, valid_mcsr_rd, valid_mcsr_wr,
    output mcsr_set, mcsr_clr, write_data,
    output dbg_csr_wr, dbg_csr_addr, dbg_write_data,
    input  read_data
  );

  modport slave (
    input  csr_addr, valid_mcsr_rd, valid_mcsr_wr,
    input  mcsr_set, mcsr_clr, write_data,
    input  dbg_csr_wr, dbg_csr_addr, dbg_write_data,
    output read_data
  );
endinterface

// File: rtl/trigger_unit_match.sv
// Per-trigger address comparator (module trigger_match).
// Ports: i_td1/i_td2 trigger config, fetch and load/store buses, o_match.
module trigger_match
  import trigger_unit_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          i_dbg_mode,
  input  tdata1_t       i_td1,
  input  logic [DW-1:0] i_td2,
  input  logic          i_if_valid,
  input  logic [DW-1:0] i_if_pc,
  input  logic          i_mem_valid,
  input  logic          i_mem_st,
  input  logic [DW-1:0] i_mem_addr,
  output logic          o_match
);

  function automatic logic cmp(
    logic [1:0]    mt,
    logic [DW-1:0] a,
    logic [DW-1:0] t
  );
    logic r;
    unique case (mt)
      MATCH_EQ: r = (a == t);
      MATCH_GE: r = (a >= t);
      MATCH_LT: r = (a < t);
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

  logic w_ex_hit;
  logic w_mem_en;
  logic w_mem_hit;

  assign w_ex_hit  = i_td1.exec & i_if_valid &
                     cmp(i_td1.mtch, i_if_pc, i_td2);
  assign w_mem_en  = i_mem_st ? i_td1.store : i_td1.load;
  assign w_mem_hit = w_mem_en & i_mem_valid &
                     cmp(i_td1.mtch, i_mem_addr, i_td2);
  assign o_match   = i_td1.m & ~i_dbg_mode &
                     (w_ex_hit | w_mem_hit);

endmodule

// File: rtl/trigger_unit.sv
// Trigger CSR file: tselect/tdata1-3/tinfo, WARL, hit bits, request FSM.
// Ports: cpu_clk/cpu_rstn, csr bus (slave), dbg_mode, fetch/mem buses,
// trig_req/trig_dbg/trig_idx out, trig_ack in. DATA_WIDTH must be >= 32.
module trigger_unit
  import trigger_unit_pkg::*;
#(
  parameter  int NUM_TRIG   = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int SEL_W = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  trigger_unit_if.slave         csr,
  input  logic                  dbg_mode,
  input  logic                  if_valid,
  input  logic [DATA_WIDTH-1:0] if_pc,
  input  logic                  mem_valid,
  input  logic                  mem_st,
  input  logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  trig_req,
  output logic                  trig_dbg,
  output logic [SEL_W-1:0]      trig_idx,
  input  logic                  trig_ack
);

  localparam int DW = DATA_WIDTH;

  tdata1_t          r_td1 [NUM_TRIG];
  logic [DW-1:0]    r_td2 [NUM_TRIG];
  logic [SEL_W-1:0] r_tsel;
  req_state_e       r_state;
  req_state_e       w_state_nxt;
  logic             r_dbg;
  logic [SEL_W-1:0] r_idx;

  tdata1_t          w_sel_td1;
  logic [DW-1:0]    w_sel_td2;
  logic             w_wr_en;
  logic             w_wr_dbg;
  logic [11:0]      w_wr_addr;
  logic [DW-1:0]    w_old;
  logic [DW-1:0]    w_wdata;
  logic             w_locked;
  logic             w_wr_tsel;
  logic             w_wr_td1;
  logic             w_wr_td2;
  tdata1_t          w_new_td1;
  logic [NUM_TRIG-1:0] w_match;
  logic             w_any;
  logic [SEL_W-1:0] w_fire_idx;
  logic             w_fire_dbg;
  logic             w_load;

  assign w_sel_td1 = r_td1[r_tsel];
  assign w_sel_td2 = r_td2[r_tsel];

  function automatic logic [DW-1:0] csr_val(
    logic [11:0]      a,
    logic [SEL_W-1:0] ts,
    tdata1_t          t1,
    logic [DW-1:0]    t2
  );
    logic [DW-1:0] r;
    r = '0;
    unique case (1'b1)
      (a == CSR_TSELECT): r = DW'(ts);
      (a == CSR_TDATA1):  r = DW'(pack_td1(t1));
      (a == CSR_TDATA2):  r = t2;
      (a == CSR_TINFO):   r = DW'(1 << TYPE_MC);
      default:            r = '0;
    endcase
    return r;
  endfunction

  assign csr.read_data = csr.valid_mcsr_rd ?
    csr_val(csr.csr_addr, r_tsel, w_sel_td1, w_sel_td2) : '0;

  // Debugger write pre-empts a same-cycle core write.
  always_comb begin
    w_wr_dbg  = csr.dbg_csr_wr;
    w_wr_en   = csr.dbg_csr_wr | csr.valid_mcsr_wr;
    w_wr_addr = csr.dbg_csr_wr ? csr.dbg_csr_addr : csr.csr_addr;
    w_old     = csr_val(csr.csr_addr, r_tsel, w_sel_td1, w_sel_td2);
    w_wdata   = csr.write_data;
    unique case (1'b1)
      csr.dbg_csr_wr: w_wdata = csr.dbg_write_data;
      csr.mcsr_set:   w_wdata = w_old | csr.write_data;
      csr.mcsr_clr:   w_wdata = w_old & ~csr.write_data;
      default:        w_wdata = csr.write_data;
    endcase
  end

  // Debug-owned triggers are frozen for the core outside debug mode.
  assign w_locked  = w_sel_td1.dmode & ~w_wr_dbg & ~dbg_mode;
  assign w_wr_tsel = w_wr_en & (w_wr_addr == CSR_TSELECT) &
                     (w_wdata < DW'(NUM_TRIG));
  assign w_wr_td1  = w_wr_en & (w_wr_addr == CSR_TDATA1) & ~w_locked;
  assign w_wr_td2  = w_wr_en & (w_wr_addr == CSR_TDATA2) & ~w_locked;

  always_comb begin
    w_new_td1       = '0;
    w_new_td1.dmode = (w_wr_dbg | dbg_mode) ? w_wdata[TD1_DMODE]
                                            : w_sel_td1.dmode;
    w_new_td1.hit   = w_wdata[TD1_HIT];
    w_new_td1.act   = (w_wdata[TD1_ACT +: 4] == ACT_DBG) &
                      w_new_td1.dmode;
    w_new_td1.mtch  = legal_match(w_wdata[TD1_MATCH +: 4]);
    w_new_td1.m     = w_wdata[TD1_M];
    w_new_td1.exec  = w_wdata[TD1_EXEC];
    w_new_td1.store = w_wdata[TD1_STORE];
    w_new_td1.load  = w_wdata[TD1_LOAD];
  end

  for (genvar g = 0; g < NUM_TRIG; g++) begin : g_trig
    trigger_match #(.DW(DW)) u_match (
      .i_dbg_mode  (dbg_mode),
      .i_td1       (r_td1[g]),
      .i_td2       (r_td2[g]),
      .i_if_valid  (if_valid),
      .i_if_pc     (if_pc),
      .i_mem_valid (mem_valid),
      .i_mem_st    (mem_st),
      .i_mem_addr  (mem_addr),
      .o_match     (w_match[g])
    );
  end

  assign w_any = |w_match;

  // Scan downwards so the lowest matching index wins.
  always_comb begin
    w_fire_idx = '0;
    w_fire_dbg = 1'b0;
    for (int i = NUM_TRIG - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_fire_idx = SEL_W'(i);
        w_fire_dbg = r_td1[i].act;
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_tsel <= '0;
      for (int i = 0; i < NUM_TRIG; i++) begin
        r_td1[i] <= '0;
        r_td2[i] <= '0;
      end
    end else begin
      if (w_wr_tsel) r_tsel <= w_wdata[SEL_W-1:0];
      for (int i = 0; i < NUM_TRIG; i++) begin
        if (w_wr_td1 && r_tsel == SEL_W'(i))
          r_td1[i] <= w_new_td1;
        else if (w_match[i])
          r_td1[i].hit <= 1'b1;
        if (w_wr_td2 && r_tsel == SEL_W'(i))
          r_td2[i] <= w_wdata;
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    if (dbg_mode) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            w_state_nxt = ST_PEND;
            w_load      = 1'b1;
          end
        end
        ST_PEND: begin
          if (trig_ack) begin
            w_state_nxt = w_any ? ST_PEND : ST_IDLE;
            w_load      = w_any;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_idx <= '0;
      r_dbg <= 1'b0;
    end else if (w_load) begin
      r_idx <= w_fire_idx;
      r_dbg <= w_fire_dbg;
    end else if (w_state_nxt == ST_IDLE) begin
      r_idx <= '0;
      r_dbg <= 1'b0;
    end
  end

  assign trig_req = (r_state == ST_PEND);
  assign trig_dbg = r_dbg;
  assign trig_idx = r_idx;

endmodule

// File: tb/tb_trigger_unit.sv
// Directed bench for trigger_unit: CSR vector table plus
// hand-written request/hit/debug sequences.
module tb_trigger_unit;
  import trigger_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dbg_mode = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0;
  logic        mem_valid = 1'b0;
  logic        mem_st = 1'b0;
  logic [31:0] mem_addr = '0;
  logic        trig_req;
  logic        trig_dbg;
  logic [1:0]  trig_idx;
  logic        trig_ack = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  trigger_unit_if #(.DW(32)) csr_if ();

  trigger_unit #(.NUM_TRIG(4), .DATA_WIDTH(32)) dut (
    .cpu_clk   (clk),
    .cpu_rstn  (rst_n),
    .csr       (csr_if),
    .dbg_mode  (dbg_mode),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .mem_valid (mem_valid),
    .mem_st    (mem_st),
    .mem_addr  (mem_addr),
    .trig_req  (trig_req),
    .trig_dbg  (trig_dbg),
    .trig_idx  (trig_idx),
    .trig_ack  (trig_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic        dm;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [11:0] raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic bus_idle();
    csr_if.valid_mcsr_rd  = 1'b0;
    csr_if.valid_mcsr_wr  = 1'b0;
    csr_if.mcsr_set       = 1'b0;
    csr_if.mcsr_clr       = 1'b0;
    csr_if.dbg_csr_wr     = 1'b0;
  endtask

  // kind: 0 core write, 1 debugger, 2 set, 3 clr, 4 none
  task automatic csr_wr(input int kind, input logic dm,
                        input logic [11:0] a,
                        input logic [31:0] d);
    dbg_mode = dm;
    if (kind == 1) begin
      csr_if.dbg_csr_wr     = 1'b1;
      csr_if.dbg_csr_addr   = a;
      csr_if.dbg_write_data = d;
    end else if (kind != 4) begin
      csr_if.valid_mcsr_wr = 1'b1;
      csr_if.mcsr_set      = (kind == 2);
      csr_if.mcsr_clr      = (kind == 3);
      csr_if.csr_addr      = a;
      csr_if.write_data    = d;
    end
    @(negedge clk);
    bus_idle();
    dbg_mode = 1'b0;
  endtask

  task automatic csr_rd(input logic [11:0] a,
                        output logic [31:0] d);
    csr_if.valid_mcsr_rd = 1'b1;
    csr_if.csr_addr      = a;
    #1;
    d = csr_if.read_data;
    csr_if.valid_mcsr_rd = 1'b0;
  endtask

  task automatic chk_req(input string nm, input logic r,
                         input logic [1:0] idx, input logic dbg);
    check({nm, "_req"}, {31'b0, trig_req}, {31'b0, r});
    if (r) begin
      check({nm, "_idx"}, {30'b0, trig_idx}, {30'b0, idx});
      check({nm, "_dbg"}, {31'b0, trig_dbg}, {31'b0, dbg});
    end
  endtask

  task automatic ack();
    trig_ack = 1'b1;
    @(negedge clk);
    trig_ack = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    bus_idle();
    csr_if.csr_addr       = '0;
    csr_if.write_data     = '0;
    csr_if.dbg_csr_addr   = '0;
    csr_if.dbg_write_data = '0;

    tbl[0]  = '{0, 1'b0, CSR_TSELECT, 32'd4, CSR_TSELECT, 32'd0, "tsel_warl"};
    tbl[1]  = '{0, 1'b0, CSR_TSELECT, 32'd3, CSR_TSELECT, 32'd3, "tsel_wr"};
    tbl[2]  = '{0, 1'b0, CSR_TDATA2, 32'h8000_0100, CSR_TDATA2, 32'h8000_0100, "td2_wr"};
    tbl[3]  = '{0, 1'b0, CSR_TDATA3, 32'h0000_FFFF, CSR_TDATA3, 32'h0, "td3_zero"};
    tbl[4]  = '{4, 1'b0, CSR_TDATA3, 32'h0, CSR_TINFO, 32'h4, "tinfo"};
    tbl[5]  = '{0, 1'b0, CSR_TDATA1, 32'h0800_0000, CSR_TDATA1, 32'h2000_0000, "dmode_core"};
    tbl[6]  = '{0, 1'b0, CSR_TDATA1, 32'h0000_5000, CSR_TDATA1, 32'h2000_0000, "act5"};
    tbl[7]  = '{0, 1'b0, CSR_TDATA1, 32'h0000_0080, CSR_TDATA1, 32'h2000_0000, "match1"};
    tbl[8]  = '{0, 1'b0, CSR_TDATA1, 32'h0000_1000, CSR_TDATA1, 32'h2000_0000, "act1_nodm"};
    tbl[9]  = '{0, 1'b0, CSR_TDATA1, 32'h0000_0147, CSR_TDATA1, 32'h2000_0147, "td1_wr"};
    tbl[10] = '{2, 1'b0, CSR_TDATA1, 32'h0000_0180, CSR_TDATA1, 32'h2000_01C7, "td1_set"};
    tbl[11] = '{3, 1'b0, CSR_TDATA1, 32'h0000_0007, CSR_TDATA1, 32'h2000_01C0, "td1_clr"};
    tbl[12] = '{0, 1'b1, CSR_TDATA1, 32'h0800_1044, CSR_TDATA1, 32'h2800_1044, "dm_wr"};
    tbl[13] = '{0, 1'b0, CSR_TDATA1, 32'h0000_0044, CSR_TDATA1, 32'h2800_1044, "lock_td1"};
    tbl[14] = '{0, 1'b0, CSR_TDATA2, 32'h0000_1234, CSR_TDATA2, 32'h8000_0100, "lock_td2"};
    tbl[15] = '{1, 1'b0, CSR_TDATA1, 32'h0000_0000, CSR_TDATA1, 32'h2000_0000, "dbg_wr"};
    tbl[16] = '{0, 1'b0, 12'h300, 32'hFFFF_FFFF, 12'h300, 32'h0, "other_addr"};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    csr_rd(CSR_TDATA1, rd);  check("rst_td1", rd, 32'h2000_0000);
    csr_rd(CSR_TSELECT, rd); check("rst_tsel", rd, 32'h0);
    chk_req("rst", 1'b0, 2'd0, 1'b0);

    for (int i = 0; i < 17; i++) begin
      csr_wr(tbl[i].kind, tbl[i].dm, tbl[i].waddr, tbl[i].wdata);
      csr_rd(tbl[i].raddr, rd);
      check(tbl[i].name, rd, tbl[i].exp);
    end

    // Trig1 execute eq 0x100, breakpoint action
    csr_wr(0, 1'b0, CSR_TSELECT, 32'd1);
    csr_wr(0, 1'b0, CSR_TDATA2, 32'h100);
    csr_wr(0, 1'b0, CSR_TDATA1, 32'h44);
    if_pc = 32'h100; if_valid = 1'b1;
    #1 chk_req("lat0", 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    if_valid = 1'b0;
    chk_req("exec", 1'b1, 2'd1, 1'b0);
    csr_rd(CSR_TDATA1, rd); check("exec_hit", rd, 32'h2010_0044);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_req("hold", 1'b1, 2'd1, 1'b0);
    end
    ack();
    chk_req("acked", 1'b0, 2'd0, 1'b0);

    // Trig0 load >= 0x2000, trig2 store < 0x10
    csr_wr(0, 1'b0, CSR_TSELECT, 32'd0);
    csr_wr(0, 1'b0, CSR_TDATA2, 32'h2000);
    csr_wr(0, 1'b0, CSR_TDATA1, 32'h141);
    csr_wr(0, 1'b0, CSR_TSELECT, 32'd2);
    csr_wr(0, 1'b0, CSR_TDATA2, 32'h10);
    csr_wr(0, 1'b0, CSR_TDATA1, 32'h1C2);
    mem_valid = 1'b1; mem_st = 1'b1; mem_addr = 32'h8;
    @(negedge clk);
    mem_valid = 1'b0;
    chk_req("store", 1'b1, 2'd2, 1'b0);
    mem_valid = 1'b1; mem_st = 1'b0; mem_addr = 32'h3000;
    @(negedge clk);
    mem_valid = 1'b0;
    chk_req("pend_ld", 1'b1, 2'd2, 1'b0);
    csr_wr(0, 1'b0, CSR_TSELECT, 32'd0);
    csr_rd(CSR_TDATA1, rd); check("ld_hit0", rd, 32'h2010_0141);
    csr_wr(0, 1'b0, CSR_TSELECT, 32'd3);
    csr_rd(CSR_TDATA1, rd); check("no_hit3", rd, 32'h2000_0000);
    chk_req("still", 1'b1, 2'd2, 1'b0);
    trig_ack = 1'b1;
    mem_valid = 1'b1; mem_st = 1'b0; mem_addr = 32'h3000;
    @(negedge clk);
    trig_ack = 1'b0; mem_valid = 1'b0;
    chk_req("b2b", 1'b1, 2'd0, 1'b0);
    ack();
    chk_req("b2b_clr", 1'b0, 2'd0, 1'b0);

    // Trig3 debug-owned, action enter-debug
    csr_wr(0, 1'b0, CSR_TDATA2, 32'h200);
    csr_wr(0, 1'b1, CSR_TDATA1, 32'h0800_1044);
    csr_wr(0, 1'b0, CSR_TDATA1, 32'h0000_0000);
    csr_rd(CSR_TDATA1, rd); check("dm_lock", rd, 32'h2800_1044);
    if_pc = 32'h200; if_valid = 1'b1;
    @(negedge clk);
    if_valid = 1'b0;
    chk_req("dbg_act", 1'b1, 2'd3, 1'b1);
    ack();

    // Debug mode suppresses matches and clears pending request
    csr_wr(0, 1'b0, CSR_TSELECT, 32'd1);
    csr_wr(0, 1'b0, CSR_TDATA1, 32'h44);
    dbg_mode = 1'b1; if_pc = 32'h100; if_valid = 1'b1;
    @(negedge clk);
    if_valid = 1'b0; dbg_mode = 1'b0;
    chk_req("dm_noreq", 1'b0, 2'd0, 1'b0);
    csr_rd(CSR_TDATA1, rd); check("dm_nohit", rd, 32'h2000_0044);
    if_valid = 1'b1;
    @(negedge clk);
    if_valid = 1'b0;
    chk_req("refire", 1'b1, 2'd1, 1'b0);
    dbg_mode = 1'b1;
    @(negedge clk);
    dbg_mode = 1'b0;
    chk_req("dm_clr", 1'b0, 2'd0, 1'b0);

    // Debugger beats core in the same cycle
    csr_if.valid_mcsr_wr  = 1'b1;
    csr_if.csr_addr       = CSR_TSELECT;
    csr_if.write_data     = 32'd1;
    csr_if.dbg_csr_wr     = 1'b1;
    csr_if.dbg_csr_addr   = CSR_TSELECT;
    csr_if.dbg_write_data = 32'd2;
    @(negedge clk);
    bus_idle();
    csr_rd(CSR_TSELECT, rd); check("dbg_wins", rd, 32'd2);
    csr_if.csr_addr = CSR_TSELECT;
    #1 check("no_rd", csr_if.read_data, 32'h0);

    // Async reset with request pending
    if_pc = 32'h100; if_valid = 1'b1;
    @(negedge clk);
    if_valid = 1'b0;
    chk_req("pre_rst", 1'b1, 2'd1, 1'b0);
    rst_n = 1'b0;
    #1 chk_req("mid_rst", 1'b0, 2'd0, 1'b0);
    csr_rd(CSR_TSELECT, rd); check("rst_tsel2", rd, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
